// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared datapath bus constants and destination helpers
package cpu_bus_pkg;

  localparam int DEFAULT_DW = 32;
  localparam int DEST_W     = 5;

  // Special destinations are encoded as offsets above the last general register.
  localparam int DEST_HI   = 0;
  localparam int DEST_LO   = 1;
  localparam int DEST_PC   = 2;
  localparam int DEST_LAST = DEST_PC;

  // True when the code names a real register for a bank with nregs general registers.
  function automatic logic dest_legal(input logic [DEST_W-1:0] dest, input int nregs);
    return int'(dest) <= nregs + DEST_LAST;
  endfunction

endpackage

// File: rtl/bus_reg_sink_if.sv
// rtl/bus_reg_sink_if.sv - load request handshake between bus control and register sink
interface bus_reg_sink_if
  import cpu_bus_pkg::*;
#(
  parameter int DW = DEFAULT_DW
);

  logic [DW-1:0]     busMuxIn;
  logic              ldValid;
  logic [DEST_W-1:0] ldDest;
  logic              ldReady;
  logic              hold;

  modport master (output busMuxIn, ldValid, ldDest, hold, input ldReady);
  modport slave  (input busMuxIn, ldValid, ldDest, hold, output ldReady);

endinterface

// File: rtl/bus_reg_sink_reg32.sv
// rtl/bus_reg_sink_reg32.sv - DW-bit register with synchronous active-low clear and load enable
module bus_reg32 #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          ld,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  // Hold value unless loaded; clear wins over load.
  always_ff @(posedge clk) begin
    if (!clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bus_reg_sink.sv
// rtl/bus_reg_sink.sv - bus destination register bank with one write pipeline stage (option: R0_ZERO_EN)
module bus_reg_sink
  import cpu_bus_pkg::*;
#(
  parameter int DW    = DEFAULT_DW,
  parameter int NREGS = 16,
  parameter int CW    = 16
) (
  input  logic                clk,
  input  logic                clr,
  bus_reg_sink_if.slave       bus,
  output logic [NREGS*DW-1:0] regFlat,
  output logic [DW-1:0]       hiQ,
  output logic [DW-1:0]       loQ,
  output logic [DW-1:0]       pcQ,
  output logic                destErr,
  output logic [CW-1:0]       wrCount
);

  localparam int NBANK = NREGS + DEST_LAST + 1;
`ifdef R0_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  logic              accept;
  logic              pend_valid;
  logic [DEST_W-1:0] pend_dest;
  logic [DW-1:0]     pend_data;
  logic              pend_legal;
  logic [NBANK-1:FIRST] ld_en;
  logic [DW-1:0]     q [NBANK];

  // Hold only blocks new captures; a pending write drains regardless.
  assign bus.ldReady = ~bus.hold;
  assign accept      = bus.ldValid & bus.ldReady;
  assign pend_legal  = pend_valid & dest_legal(pend_dest, NREGS);

  // Pend stage: one captured request, refilled every cycle a new one is accepted.
  always_ff @(posedge clk) begin
    if (!clr) begin
      pend_valid <= 1'b0;
      pend_dest  <= '0;
      pend_data  <= '0;
    end else begin
      pend_valid <= accept;
      if (accept) begin
        pend_dest <= bus.ldDest;
        pend_data <= bus.busMuxIn;
      end
    end
  end

  // One-hot bank enable decoded from the pending destination.
  always_comb begin
    ld_en = '0;
    for (int i = FIRST; i < NBANK; i++) begin
      ld_en[i] = pend_legal && (pend_dest == DEST_W'(i));
    end
  end

  // Retire bookkeeping: illegal codes raise a sticky error, legal ones are counted.
  always_ff @(posedge clk) begin
    if (!clr) begin
      destErr <= 1'b0;
      wrCount <= '0;
    end else begin
      if (pend_valid && !pend_legal) destErr <= 1'b1;
      if (pend_legal) wrCount <= wrCount + CW'(1);
    end
  end

`ifdef R0_ZERO_EN
  assign q[0] = '0;
`endif

  genvar g;
  generate
    for (g = FIRST; g < NBANK; g++) begin : g_bank
      bus_reg32 #(.DW(DW)) u_reg (
        .clk (clk),
        .clr (clr),
        .ld  (ld_en[g]),
        .d   (pend_data),
        .q   (q[g])
      );
    end
    for (g = 0; g < NREGS; g++) begin : g_flat
      assign regFlat[g*DW +: DW] = q[g];
    end
  endgenerate

  assign hiQ = q[NREGS + DEST_HI];
  assign loQ = q[NREGS + DEST_LO];
  assign pcQ = q[NREGS + DEST_PC];

endmodule

// File: tb/tb_bus_reg_sink.sv
// tb/tb_bus_reg_sink.sv - directed self-checking bench for bus_reg_sink (option: R0_ZERO_EN)
module tb_bus_reg_sink;

  logic         clk = 1'b0;
  logic         clr;
  logic [511:0] regFlat;
  logic [31:0]  hiQ, loQ, pcQ;
  logic         destErr;
  logic [15:0]  wrCount;

  int total = 0;
  int bad   = 0;

  bus_reg_sink_if #(.DW(32)) bus ();

  bus_reg_sink #(.DW(32), .NREGS(16), .CW(16)) dut (
    .clk     (clk),
    .clr     (clr),
    .bus     (bus),
    .regFlat (regFlat),
    .hiQ     (hiQ),
    .loQ     (loQ),
    .pcQ     (pcQ),
    .destErr (destErr),
    .wrCount (wrCount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rn(input int n);
    return regFlat[n*32 +: 32];
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] d, input logic [31:0] x);
    bus.ldValid  = v;
    bus.ldDest   = d;
    bus.busMuxIn = x;
  endtask

  logic [31:0] acc;

  initial begin
    clr = 1'b0;
    bus.hold = 1'b0;
    drive(1'b0, 5'd0, 32'h0);
    step();
    step();
    clr = 1'b1;

    // Reset state
    acc = 32'h0;
    for (int i = 0; i < 16; i++) acc = acc | rn(i);
    check_val("rst_regs", acc | hiQ | loQ | pcQ, 32'h0);
    check_val("rst_cnt", {16'h0, wrCount}, 32'h0);
    check_val("rst_err", {31'h0, destErr}, 32'h0);
    check_val("rst_ready", {31'h0, bus.ldReady}, 32'h1);

    // 1: single write, two-edge latency
    drive(1'b1, 5'd3, 32'hDEADBEEF);
    step();
    drive(1'b0, 5'd0, 32'h0);
    check_val("t1_lat", rn(3), 32'h0);
    step();
    check_val("t1_r3", rn(3), 32'hDEADBEEF);
    check_val("t1_cnt", {16'h0, wrCount}, 32'd1);
    acc = 32'h0;
    for (int i = 0; i < 16; i++) if (i != 3) acc = acc | rn(i);
    check_val("t1_others", acc | hiQ | loQ | pcQ, 32'h0);

    // 2: back-to-back HI/LO/PC
    drive(1'b1, 5'd16, 32'h1);
    step();
    drive(1'b1, 5'd17, 32'h2);
    step();
    drive(1'b1, 5'd18, 32'h3);
    check_val("t2_hi_first", hiQ, 32'h1);
    check_val("t2_lo_notyet", loQ, 32'h0);
    step();
    drive(1'b0, 5'd0, 32'h0);
    check_val("t2_lo", loQ, 32'h2);
    check_val("t2_pc_notyet", pcQ, 32'h0);
    step();
    check_val("t2_pc", pcQ, 32'h3);
    check_val("t2_cnt", {16'h0, wrCount}, 32'd4);

    // 3: same destination twice in a row
    drive(1'b1, 5'd5, 32'hAAAA0000);
    step();
    drive(1'b1, 5'd5, 32'h5555FFFF);
    step();
    drive(1'b0, 5'd0, 32'h0);
    check_val("t3_old", rn(5), 32'hAAAA0000);
    step();
    check_val("t3_new", rn(5), 32'h5555FFFF);
    check_val("t3_cnt", {16'h0, wrCount}, 32'd6);

    // 4: hold blocks capture, pending write still retires
    drive(1'b1, 5'd7, 32'h00000077);
    step();
    bus.hold = 1'b1;
    drive(1'b1, 5'd8, 32'h00000099);
    #1;
    check_val("t4_ready", {31'h0, bus.ldReady}, 32'h0);
    step();
    check_val("t4_r7", rn(7), 32'h00000077);
    check_val("t4_cnt", {16'h0, wrCount}, 32'd7);
    step();
    step();
    check_val("t4_r8_held", rn(8), 32'h0);
    check_val("t4_cnt_held", {16'h0, wrCount}, 32'd7);
    bus.hold = 1'b0;
    step();
    drive(1'b0, 5'd0, 32'h0);
    check_val("t4_r8_lat", rn(8), 32'h0);
    step();
    check_val("t4_r8", rn(8), 32'h00000099);
    check_val("t4_cnt2", {16'h0, wrCount}, 32'd8);

    // 5: illegal destination
    drive(1'b1, 5'd25, 32'h12345678);
    step();
    drive(1'b0, 5'd0, 32'h0);
    check_val("t5_err_early", {31'h0, destErr}, 32'h0);
    step();
    check_val("t5_err", {31'h0, destErr}, 32'h1);
    check_val("t5_cnt", {16'h0, wrCount}, 32'd8);
    check_val("t5_r3", rn(3), 32'hDEADBEEF);
    check_val("t5_pc", pcQ, 32'h3);
    step();
    step();
    check_val("t5_sticky", {31'h0, destErr}, 32'h1);

    // 6: reset discards a pending write
    drive(1'b1, 5'd2, 32'h22222222);
    step();
    drive(1'b0, 5'd0, 32'h0);
    clr = 1'b0;
    step();
    clr = 1'b1;
    check_val("t6_r2", rn(2), 32'h0);
    check_val("t6_cnt", {16'h0, wrCount}, 32'd0);
    check_val("t6_err", {31'h0, destErr}, 32'h0);
    check_val("t6_r3", rn(3), 32'h0);
    step();
    check_val("t6_r2_after", rn(2), 32'h0);
    check_val("t6_cnt_after", {16'h0, wrCount}, 32'd0);

    // R0 write
    drive(1'b1, 5'd0, 32'hFFFFFFFF);
    step();
    drive(1'b0, 5'd0, 32'h0);
    step();
`ifdef R0_ZERO_EN
    check_val("r0_val", rn(0), 32'h0);
`else
    check_val("r0_val", rn(0), 32'hFFFFFFFF);
`endif
    check_val("r0_cnt", {16'h0, wrCount}, 32'd1);
    check_val("r0_err", {31'h0, destErr}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
